multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main controller for the multicycle RV32I core. It sequences one shared ALU, one unified
//  instruction/data memory port and the register file across several cycles per instruction.
//  It replaces the single-cycle main decoder. The existing ALU decoder still turns alu_op
//  into the ALU control code. Memory accesses stall via a ready handshake.
// PARAMETERS
//  RETIRE_W     32  width of the retired-instruction counter (wraps modulo 2^RETIRE_W)
//  MEM_WAIT_EN  1   1: honour mem_ready; 0: treat mem_ready as always 1
// PORTS
//  clk           in   1         core clock, rising edge
//  reset         in   1         asynchronous, active-high; forces FETCH
//  op            in   7         opcode field of the instruction register
//  zero          in   1         ALU zero flag
//  mem_ready     in   1         memory access completes this cycle
//  pc_write      out  1         PC register enable
//  adr_src       out  1         memory address mux: 0=PC, 1=ALU result reg
//  mem_write     out  1         memory write strobe
//  ir_write      out  1         instruction register (and old-PC register) enable
//  reg_write     out  1         register file write enable
//  alu_src_a     out  2         00=PC, 01=old PC, 10=rs1 data
//  alu_src_b     out  2         00=rs2 data, 01=immediate, 10=constant 4
//  alu_op        out  2         to ALU decoder: 00=add, 01=sub, 10=funct-decoded
//  result_src    out  2         00=ALU out reg, 01=data reg, 10=ALU result
//  imm_src       out  2         00=I, 01=S, 10=B, 11=J; combinational from op; 00 if op unknown
//  illegal_op    out  1         one-cycle pulse when DECODE sees an unknown opcode
//  retired       out  RETIRE_W  count of completed instructions
// BEHAVIOUR
//  - State register: resets asynchronously to FETCH; retired resets to 0.
//  - While reset is high, all strobes are 0: pc_write, mem_write, ir_write, reg_write, illegal_op.
//  - All outputs are Moore outputs decoded from the state, except the following:
//    - pc_write = pc_update | (branch & zero).
//    - In FETCH, ir_write and pc_update are gated by mem_ready.
//    - imm_src is decoded from op.
//  - Any output not listed for a state is 0.
//  - FETCH: adr_src=0, srcA=00, srcB=10, alu_op=00, result_src=10.
//    - Hold FETCH while mem_ready=0.
//    - On mem_ready=1, assert ir_write and pc_update, then go to DECODE.
//  - DECODE: srcA=01, srcB=01, alu_op=00 (this precomputes the branch/jal target). Next state by op:
//    - 0000011 (lw) or 0100011 (sw) -> MEMADR
//    - 0110011 (R-type) -> EXECR
//    - 0010011 (I-type ALU) -> EXECI
//    - 1100011 (beq) -> BEQ
//    - 1101111 (jal) -> JAL
//    - any other opcode -> FETCH, with an illegal_op pulse; retired is not incremented
//  - MEMADR: srcA=10, srcB=01, alu_op=00. Next: MEMREAD for lw, MEMWRITE for sw.
//  - MEMREAD: adr_src=1, result_src=00. Hold while mem_ready=0, then go to MEMWB.
//  - MEMWB: result_src=01, reg_write=1, then FETCH.
//  - MEMWRITE: adr_src=1, result_src=00, mem_write=1.
//    - mem_write stays high every cycle until mem_ready=1, then go to FETCH.
//  - EXECR: srcA=10, srcB=00, alu_op=10, then ALUWB.
//  - EXECI: srcA=10, srcB=01, alu_op=10, then ALUWB.
//  - ALUWB: result_src=00, reg_write=1, then FETCH.
//  - BEQ: srcA=10, srcB=00, alu_op=01, result_src=00, branch=1. PC loads the target only if zero=1. Then FETCH.
//  - JAL: srcA=01, srcB=10, alu_op=00, result_src=00, pc_update=1 (rd <- PC+4 via ALUWB). Then ALUWB.
//  - retired increments by 1 on the final cycle of every legal instruction:
//    - MEMWB, ALUWB and BEQ exits;
//    - MEMWRITE exit when mem_ready=1.
//    - JAL counts once, at its ALUWB.
//  - Latency with no stalls (cycles): lw 5, sw 4, R/I 4, beq 3, jal 4. Each memory-wait cycle adds 1.
//  - Reset asserted mid-instruction: abandon at once; no write strobes while reset is high; restart in FETCH.
//  - mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE and ignored in all other states.
// STRUCTURE
//  - Shared package riscv_ctrl_pkg:
//    - mc_state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL;
//    - OP_* opcode localparams;
//    - SRCA_*/SRCB_*/RES_*/IMM_* select constants.
//  - One sub-module, imm_src_dec (op -> imm_src). Everything else is a single state register plus
//    always_comb next-state and output blocks.
// TESTING
//  - lw, mem_ready tied 1:
//    - states FETCH,DECODE,MEMADR,MEMREAD,MEMWB;
//    - reg_write high only in cycle 5;
//    - retired 0->1.
//  - sw with mem_ready=0 for 3 cycles in MEMWRITE:
//    - mem_write high 4 consecutive cycles, adr_src=1;
//    - FETCH on the next cycle; retired +1 exactly once.
//  - beq, zero=1 then zero=0:
//    - pc_write=1 in BEQ only when zero=1;
//    - alu_op=01, imm_src=10, 3 cycles each.
//  - jal (op=1101111):
//    - pc_write=1 in JAL, then reg_write=1 with result_src=00 in ALUWB;
//    - imm_src=11; retired +1.
//  - op=1111111: illegal_op pulses 1 cycle in DECODE; FETCH next; retired unchanged.
//  - reset raised in EXECR between clock edges:
//    - state=FETCH immediately (asynchronous);
//    - all strobes 0 while high; retired=0;
//    - a normal FETCH occurs once reset drops.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller.
//  - mc_state_t : controller state encoding
//  - OP_*       : opcode values the controller understands
//  - SRCA_*/SRCB_*/ALUOP_*/RES_*/IMM_* : datapath mux select codes
//  - is_known_op: true for every opcode DECODE can dispatch
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } mc_state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic is_known_op(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: is_known_op = 1'b1;
      default:                                         is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format decoder.
//  op      in  7  opcode field of the instruction register
//  imm_src out 2  immediate format select (I/S/B/J); I for anything without
//                 its own format, including unknown opcodes
module imm_src_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main controller of the multicycle RV32I core. Sequences the shared ALU,
// the unified memory port and the register file over several cycles.
//  clk, reset            clock / async active-high reset (forces FETCH)
//  op, zero, mem_ready   opcode, ALU zero flag, memory completion
//  pc_write, adr_src, mem_write, ir_write, reg_write   datapath strobes/muxes
//  alu_src_a, alu_src_b, alu_op, result_src, imm_src   datapath selects
//  illegal_op            one-cycle pulse on an unknown opcode in DECODE
//  retired               completed-instruction counter (wraps)
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int RETIRE_W    = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          result_src,
  output logic [1:0]          imm_src,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired
);

  mc_state_t state_q, state_d;

  logic mem_rdy;
  logic pc_update, branch;
  logic mem_write_s, ir_write_s, reg_write_s, illegal_s;
  logic retire_inc;

  // With waiting disabled every access completes in its first cycle.
  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  imm_src_dec u_imm_src_dec (
    .op      (op),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next state and raw (ungated) outputs.
  always_comb begin
    state_d     = state_q;
    adr_src     = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    result_src  = RES_ALUOUT;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    retire_inc  = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURES;
        // IR and PC+4 only latch once the instruction word is actually back.
        ir_write_s = mem_rdy;
        pc_update  = mem_rdy;
        if (mem_rdy) state_d = DECODE;
      end
      DECODE: begin
        // ALU computes PC+imm here so BEQ/JAL find the target in ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECR;
          OP_ITYPE:     state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
        illegal_s = !is_known_op(op);
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (mem_rdy) state_d = MEMWB;
      end
      MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
        retire_inc  = 1'b1;
        state_d     = FETCH;
      end
      MEMWRITE: begin
        // Strobe is held for the whole access, including wait cycles.
        adr_src     = 1'b1;
        result_src  = RES_ALUOUT;
        mem_write_s = 1'b1;
        if (mem_rdy) begin
          retire_inc = 1'b1;
          state_d    = FETCH;
        end
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        result_src  = RES_ALUOUT;
        reg_write_s = 1'b1;
        retire_inc  = 1'b1;
        state_d     = FETCH;
      end
      BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        retire_inc = 1'b1;
        state_d    = FETCH;
      end
      JAL: begin
        // PC takes the precomputed target; ALU forms old PC+4 for rd,
        // written back in ALUWB (which also does the retire count).
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_d    = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  // Strobes are forced low combinationally while reset is held, so nothing
  // is written even in the cycle reset arrives mid-instruction.
  assign pc_write   = !reset && (pc_update || (branch && zero));
  assign mem_write  = !reset && mem_write_s;
  assign ir_write   = !reset && ir_write_s;
  assign reg_write  = !reset && reg_write_s;
  assign illegal_op = !reset && illegal_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           retired <= '0;
    else if (retire_inc) retired <= retired + RETIRE_W'(1);
  end

endmodule
